// File: rtl/mul_add_nat_seq_if.sv
// Operand/result bundle for mul_add_nat_seq: soc/x/y/c from the consumer, eoc/m back.
// master = consumer side, slave = the multiply-add block.
interface mul_add_nat_seq_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic             soc;
    logic [N-1:0]     x;
    logic [M-1:0]     y;
    logic [N-1:0]     c;
    logic             eoc;
    logic [N+M-1:0]   m;

    modport master (output soc, x, y, c, input eoc, m);
    modport slave  (input soc, x, y, c, output eoc, m);
endinterface

// File: rtl/mul_add_nat_seq.sv
// Sequential shift-and-add m = x*y + c, one multiplier bit per clock.
// Optional macro MUL_ADD_SEQ_EARLY_EXIT_EN stops as soon as the remaining multiplier is zero.
module mul_add_nat_seq #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    mul_add_nat_seq_if.slave     bus,
    output logic [1:0]           dbg_state
);
    localparam int W  = N + M;
    localparam int CW = $clog2(M + 1);

    // Handshake: consumer raises soc and holds it until eoc falls; it then drops
    // soc and may start again only once eoc is back high. soc seen while busy is
    // never a restart; it only keeps the block parked in WAIT after termination.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, WAIT = 2'd2} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   xs;
    logic [W-1:0]   acc;
    logic [M-1:0]   ys;
    logic [CW-1:0]  cnt;
    logic           eoc_q;

    logic [CW-1:0]  cnt_step;
    logic [M-1:0]   ys_shift;
    logic           last_step;

    assign cnt_step = cnt + 1'b1;
    assign ys_shift = ys >> 1;

`ifdef MUL_ADD_SEQ_EARLY_EXIT_EN
    assign last_step = (cnt_step == CW'(M)) || (ys_shift == '0);
`else
    assign last_step = (cnt_step == CW'(M));
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.soc) state_nxt = CALC;
            CALC: if (last_step) state_nxt = bus.soc ? WAIT : IDLE;
            WAIT: if (!bus.soc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // eoc is registered from the next state so it lines up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xs    <= '0;
            ys    <= '0;
            acc   <= '0;
            cnt   <= '0;
            eoc_q <= 1'b1;
        end else begin
            eoc_q <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (bus.soc) begin
                        xs  <= W'(bus.x);
                        ys  <= bus.y;
                        acc <= W'(bus.c);
                        cnt <= '0;
                    end
                end
                CALC: begin
                    if (ys[0]) acc <= acc + xs;
                    xs  <= xs << 1;
                    ys  <= ys_shift;
                    cnt <= cnt_step;
                end
                default: ;
            endcase
        end
    end

    assign bus.eoc   = eoc_q;
    assign bus.m     = acc;
    assign dbg_state = state;
endmodule

// File: doc/mul_add_nat_seq.md
# mul_add_nat_seq

Sequential multiply-add for naturals in base 2, computing m = x*y + c with an N-bit multiplicand and addend, an M-bit multiplier and an (N+M)-bit result. It trades the single-cycle combinational multiplier for a shift-and-add datapath that processes one multiplier bit per clock. Operands arrive through a soc/eoc (start/end of conversion) handshake. The block targets datapaths where N and M are wide enough that a full array multiplier is too large or too slow.

## Interface
- N, default 4: width of multiplicand x and addend c, ≥ 1
- M, default 4: width of multiplier y, ≥ 1; also the worst-case iteration count
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; forces the block idle
- soc  input  1  start of conversion, driven by the consumer
- x  input  N  multiplicand, natural
- y  input  M  multiplier, natural
- c  input  N  addend, natural
- eoc  output  1  end of conversion: 1 = idle and m valid, 0 = busy
- m  output  N+M  result register

## Operation
- Internal registers:
  - state: IDLE, CALC or WAIT
  - xs (N+M bits): shifted multiplicand
  - ys (M bits): remaining multiplier
  - acc (N+M bits): accumulator; drives m directly
  - cnt: ceil(log2(M+1)) bits
- IDLE
  - eoc=1.
  - When soc=1 is sampled: xs←zero-extended x, ys←y, acc←zero-extended c, cnt←0, go to CALC.
  - x, y and c are sampled only on this edge. Later changes to them are ignored.
- CALC
  - eoc=0.
  - Each edge:
    - if ys[0]=1, acc←acc+xs (N+M-bit add, no carry out)
    - xs←xs<<1
    - ys←ys>>1
    - cnt←cnt+1
  - Termination: the step that brings cnt to M, or the early-exit condition (see Configuration), ends CALC.
  - On termination, go to IDLE if soc=0 on that edge, otherwise go to WAIT.
- WAIT
  - eoc=0. acc is final and held.
  - Go to IDLE on the first edge where soc=0.
- Handshake:
  - The consumer raises soc and holds it until eoc falls.
  - The consumer then lowers soc, and the next conversion starts only after eoc has risen again.
  - soc=1 while the block is in CALC or WAIT never restarts an operation.
- Width rule: the maximum result is (2^N−1)(2^M−1)+(2^N−1) = 2^M(2^N−1) < 2^(N+M). No overflow is possible, so there is no carry or overflow output.
- m is stable whenever eoc=1. m is undefined (intermediate partial sums) while eoc=0.

## Timing
- Reset values: eoc=1, m=0, state IDLE, cnt=0. Reset asserted mid-CALC or mid-WAIT aborts the operation immediately (asynchronously). No partial result is retained.
- soc is sampled at edge k.
  - eoc falls after edge k.
  - Without early exit, CALC occupies the cycles after edges k+1 … k+M, and acc is final after edge k+M.
  - If soc=0 at edge k+M, eoc rises after edge k+M. eoc is low for exactly M cycles.
- If soc is still 1 at termination, eoc stays low until the edge after soc is sampled low.
- Back-to-back operation: a new soc can be accepted on the first edge with eoc=1. Minimum period is M+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- MUL_ADD_SEQ_EARLY_EXIT_EN defined:
  - CALC also terminates after any step that leaves ys=0.
  - Latency becomes max(1, index of the highest set bit of y plus 1) cycles. For example, y=0 or y=1 gives 1 cycle.
  - The result is identical to the non-early-exit case.
- Not defined:
  - Latency is always exactly M cycles, independent of the operand values.

## Test plan
- N=4, M=4, x=13, y=11, c=7, soc pulse dropped while busy → m=150 (0x96); eoc low exactly 4 cycles.
- Max operands x=15, y=15, c=15 → m=240 (0xF0), with no wrap.
- x=9, y=0, c=5 → m=5. Low time of eoc is 4 cycles without the macro and 1 cycle with MUL_ADD_SEQ_EARLY_EXIT_EN.
- soc held high for 3 cycles past termination with x=3, y=4, c=0:
  - eoc stays low in WAIT until soc=0, then rises; m=12.
  - x, y and c are changed during CALC and the result is unaffected.
- reset asserted 2 cycles into CALC of x=7, y=7, c=1 → eoc=1 and m=0 immediately. A following conversion x=2, y=3, c=1 gives m=7.
